// File: rtl/open_list_pkg.sv
// Shared types and helpers for the open-list stream adapter and its push FIFO.
// MAX_VALUE is the all-ones f-value the queue reports when it is empty.
package open_list_pkg;

    localparam int F_WIDTH = 32;

    typedef logic [F_WIDTH-1:0] f_value_t;

    localparam f_value_t MAX_VALUE = '1;

    typedef enum logic {
        ISSUE  = 1'b0,
        SETTLE = 1'b1
    } adapter_state_t;

    // Width of a counter that must represent 0 .. 2*queue_size inclusive.
    function automatic int count_width(input int queue_size);
        return $clog2(2 * queue_size) + 1;
    endfunction

endpackage

// File: rtl/open_list_push_fifo.sv
// Synchronous push FIFO in front of the open-list queue.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module open_list_push_fifo
    import open_list_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  do_wr;
    logic                  do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

    // A read in the same cycle frees a slot, so a write is still legal when full.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/open_list_stream_adapter.sv
// Stream front-end for the systolic open-list min-queue: push FIFO, push/pop fusing, settle wait, head prefetch.
// Build macro OPEN_LIST_SENTINEL_CHECK_EN drops all-ones pushes and raises the sticky o_sentinel_err.
module open_list_stream_adapter
    import open_list_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int QUEUE_SIZE      = 2048,
    parameter int PUSH_FIFO_DEPTH = 4,
    parameter int SETTLE_CYCLES   = 2
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 i_push_valid,
    output logic                                 o_push_ready,
    input  logic [DATA_WIDTH-1:0]                i_push_data,
    output logic                                 o_pop_valid,
    input  logic                                 i_pop_ready,
    output logic [DATA_WIDTH-1:0]                o_pop_data,
    output logic                                 o_q_wrt,
    output logic                                 o_q_read,
    output logic [DATA_WIDTH-1:0]                o_q_node_f,
    input  logic                                 i_q_full,
    input  logic                                 i_q_empty,
    input  logic [DATA_WIDTH-1:0]                i_q_node_f,
    output logic [count_width(QUEUE_SIZE)-1:0]   o_count,
    output logic                                 o_sentinel_err
);

    localparam int              CW          = count_width(QUEUE_SIZE);
    localparam logic [CW-1:0]   CAPACITY    = CW'(2 * QUEUE_SIZE);
    localparam int              SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam int              LW          = $clog2(PUSH_FIFO_DEPTH) + 1;

    function automatic logic [CW-1:0] count_inc(input logic [CW-1:0] c);
        return (c >= CAPACITY) ? c : c + CW'(1);
    endfunction

    function automatic logic [CW-1:0] count_dec(input logic [CW-1:0] c);
        return (c == '0) ? c : c - CW'(1);
    endfunction

    adapter_state_t        state;
    logic [SW-1:0]         settle_cnt;

    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [LW-1:0]         fifo_level;
    logic                  fifo_wr;
    logic                  push_fire;
    logic                  want_push;
    logic                  want_pop;

    assign o_push_ready = !fifo_full;
    assign push_fire    = i_push_valid && o_push_ready;

`ifdef OPEN_LIST_SENTINEL_CHECK_EN
    logic sentinel_hit;

    // The all-ones value would read back as "queue empty", so it never reaches the queue.
    assign sentinel_hit = (i_push_data == {DATA_WIDTH{1'b1}});
    assign fifo_wr      = push_fire && !sentinel_hit;

    always_ff @(posedge CLK) begin
        if (RST) begin
            o_sentinel_err <= 1'b0;
        end else if (push_fire && sentinel_hit) begin
            o_sentinel_err <= 1'b1;
        end
    end
`else
    assign fifo_wr        = push_fire;
    assign o_sentinel_err = 1'b0;
`endif

    open_list_push_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (PUSH_FIFO_DEPTH)
    ) u_push_fifo (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (fifo_wr),
        .wr_data (i_push_data),
        .rd_en   (want_push),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // A full queue blocks only the push side, so a pending pair degrades to a dequeue.
    assign want_push = (state == ISSUE) && !fifo_empty && !i_q_full;
    assign want_pop  = (state == ISSUE) && !i_q_empty && (!o_pop_valid || i_pop_ready);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ISSUE;
            settle_cnt  <= '0;
            o_q_wrt     <= 1'b0;
            o_q_read    <= 1'b0;
            o_q_node_f  <= '0;
            o_pop_valid <= 1'b0;
            o_pop_data  <= '0;
            o_count     <= '0;
        end else begin
            o_q_wrt  <= want_push;
            o_q_read <= want_pop;
            if (want_push) o_q_node_f <= fifo_head;

            // The head sampled here predates any node written by the same replace.
            if (want_pop) begin
                o_pop_valid <= 1'b1;
                o_pop_data  <= i_q_node_f;
            end else if (i_pop_ready) begin
                o_pop_valid <= 1'b0;
            end

            if (want_push && !want_pop) begin
                o_count <= count_inc(o_count);
            end else if (want_pop && !want_push) begin
                o_count <= count_dec(o_count);
            end

            case (state)
                ISSUE: begin
                    if (want_push || want_pop) begin
                        state      <= SETTLE;
                        settle_cnt <= SETTLE_LAST;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= ISSUE;
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
                default: state <= ISSUE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (fifo_level <= LW'(PUSH_FIFO_DEPTH));
        end
    end

endmodule

// File: tb/tb_open_list_stream_adapter.sv
// Self-checking bench for open_list_stream_adapter against a behavioural min-queue and ordering rules.
// Exercises the OPEN_LIST_SENTINEL_CHECK_EN path when that macro is defined.
`timescale 1ns/1ps
module tb_open_list_stream_adapter;

    localparam int DATA_WIDTH      = 32;
    localparam int QUEUE_SIZE      = 4;
    localparam int PUSH_FIFO_DEPTH = 4;
    localparam int SETTLE_CYCLES   = 2;
    localparam int CAP             = 2 * QUEUE_SIZE;
    localparam int CW              = $clog2(2 * QUEUE_SIZE) + 1;

    typedef logic [DATA_WIDTH-1:0] val_t;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             i_push_valid = 1'b0;
    logic             o_push_ready;
    val_t             i_push_data = '0;
    logic             o_pop_valid;
    logic             i_pop_ready = 1'b0;
    val_t             o_pop_data;
    logic             o_q_wrt;
    logic             o_q_read;
    val_t             o_q_node_f;
    logic             i_q_full;
    logic             i_q_empty;
    val_t             i_q_node_f;
    logic [CW-1:0]    o_count;
    logic             o_sentinel_err;

    int   errors = 0;
    int   checks = 0;
    int   push_stalls = 0;
    int   wrt_seen = 0;
    int   repl_seen = 0;
    val_t last_wrt_f = '0;
    val_t popped[$];
    val_t pushed[$];
    val_t qmem[$];
    bit   force_full = 1'b0;
    logic q_empty_r = 1'b1;
    logic q_full_r  = 1'b0;
    val_t q_head_r  = '1;
    val_t all_ones  = '1;

    assign i_q_full   = q_full_r || force_full;
    assign i_q_empty  = q_empty_r;
    assign i_q_node_f = q_head_r;

    open_list_stream_adapter #(
        .DATA_WIDTH      (DATA_WIDTH),
        .QUEUE_SIZE      (QUEUE_SIZE),
        .PUSH_FIFO_DEPTH (PUSH_FIFO_DEPTH),
        .SETTLE_CYCLES   (SETTLE_CYCLES)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .i_push_valid   (i_push_valid),
        .o_push_ready   (o_push_ready),
        .i_push_data    (i_push_data),
        .o_pop_valid    (o_pop_valid),
        .i_pop_ready    (i_pop_ready),
        .o_pop_data     (o_pop_data),
        .o_q_wrt        (o_q_wrt),
        .o_q_read       (o_q_read),
        .o_q_node_f     (o_q_node_f),
        .i_q_full       (i_q_full),
        .i_q_empty      (i_q_empty),
        .i_q_node_f     (i_q_node_f),
        .o_count        (o_count),
        .o_sentinel_err (o_sentinel_err)
    );

    initial forever #5 CLK = ~CLK;

    // Behavioural min-queue: a read removes the minimum, a write inserts; a replace does both.
    initial forever begin
        @(posedge CLK);
        if (RST) begin
            qmem.delete();
        end else begin
            if (o_q_read && qmem.size() > 0) qmem.delete(0);
            if (o_q_wrt) begin
                qmem.push_back(o_q_node_f);
                qmem.sort();
            end
        end
        q_empty_r <= (qmem.size() == 0);
        q_full_r  <= (qmem.size() >= CAP);
        q_head_r  <= (qmem.size() > 0) ? qmem[0] : all_ones;
    end

    // Handshake and strobe monitor, sampled just before the committing edge.
    initial forever begin
        @(negedge CLK);
        #4;
        if (!RST) begin
            if (o_pop_valid && i_pop_ready) popped.push_back(o_pop_data);
            if (i_push_valid && o_push_ready) pushed.push_back(i_push_data);
        end
        if (o_q_wrt) begin
            wrt_seen++;
            last_wrt_f = o_q_node_f;
        end
        if (o_q_wrt && o_q_read) repl_seen++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        i_push_valid = 1'b0;
        i_pop_ready = 1'b0;
        force_full = 1'b0;
        cycles(2);
        RST = 1'b0;
        popped.delete();
        pushed.delete();
        wrt_seen = 0;
        repl_seen = 0;
    endtask

    task automatic push_val(input val_t v);
        int t = 0;
        i_push_valid = 1'b1;
        i_push_data  = v;
        while (!o_push_ready && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (!o_push_ready) push_stalls++;
        @(negedge CLK);
        i_push_valid = 1'b0;
    endtask

    task automatic drain(input int n, input int budget, output bit ok);
        int t = 0;
        i_pop_ready = 1'b1;
        while (popped.size() < n && t < budget) begin
            @(negedge CLK);
            t++;
        end
        i_pop_ready = 1'b0;
        ok = (popped.size() >= n);
    endtask

    // The first node to settle is grabbed by the empty output register; the rest leave in ascending order.
    function automatic void expect_order(input val_t src[$], output val_t dst[$]);
        val_t rest[$];
        dst.delete();
        if (src.size() == 0) return;
        dst.push_back(src[0]);
        rest = src[1:$];
        rest.sort();
        foreach (rest[i]) dst.push_back(rest[i]);
    endfunction

    task automatic test_reset();
        RST = 1'b1;
        cycles(2);
        checks++; if (o_push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready got=%b want=1", o_push_ready); end
        checks++; if (o_pop_valid !== 1'b0) begin errors++; $display("FAIL reset_pop_valid got=%b want=0", o_pop_valid); end
        checks++; if (o_pop_data !== '0) begin errors++; $display("FAIL reset_pop_data got=%0h want=0", o_pop_data); end
        checks++; if (o_q_wrt !== 1'b0) begin errors++; $display("FAIL reset_q_wrt got=%b want=0", o_q_wrt); end
        checks++; if (o_q_read !== 1'b0) begin errors++; $display("FAIL reset_q_read got=%b want=0", o_q_read); end
        checks++; if (o_q_node_f !== '0) begin errors++; $display("FAIL reset_q_node_f got=%0h want=0", o_q_node_f); end
        checks++; if (o_count !== '0) begin errors++; $display("FAIL reset_count got=%0d want=0", o_count); end
        checks++; if (o_sentinel_err !== 1'b0) begin errors++; $display("FAIL reset_sentinel_err got=%b want=0", o_sentinel_err); end
        RST = 1'b0;
    endtask

    task automatic test_sorted_drain();
        val_t src[$];
        val_t exp[$];
        bit   ok;
        do_reset();
        src = '{32'd7, 32'd3, 32'd9};
        foreach (src[i]) push_val(src[i]);
        cycles(12);
        checks++; if (o_pop_valid !== 1'b1 || o_pop_data !== 32'd7) begin errors++; $display("FAIL drain_head got=%b/%0d want=1/7", o_pop_valid, o_pop_data); end
        checks++; if (o_count !== CW'(2)) begin errors++; $display("FAIL drain_count_held got=%0d want=2", o_count); end
        drain(3, 80, ok);
        checks++; if (!ok) begin errors++; $display("FAIL drain_timeout got=%0d want=3 pops", popped.size()); end
        expect_order(src, exp);
        for (int i = 0; i < exp.size() && i < popped.size(); i++) begin
            checks++; if (popped[i] !== exp[i]) begin errors++; $display("FAIL drain_order[%0d] got=%0d want=%0d", i, popped[i], exp[i]); end
        end
        cycles(4);
        checks++; if (o_count !== '0) begin errors++; $display("FAIL drain_count_end got=%0d want=0", o_count); end
        checks++; if (o_pop_valid !== 1'b0) begin errors++; $display("FAIL drain_valid_end got=%b want=0", o_pop_valid); end
    endtask

    task automatic test_replace();
        bit ok;
        do_reset();
        push_val(32'd5);
        push_val(32'd2);
        cycles(10);
        checks++; if (repl_seen !== 1) begin errors++; $display("FAIL replace_strobe got=%0d want=1", repl_seen); end
        checks++; if (wrt_seen !== 2 || last_wrt_f !== 32'd2) begin errors++; $display("FAIL replace_node_f got=%0d/%0d want=2/2", wrt_seen, last_wrt_f); end
        checks++; if (o_pop_valid !== 1'b1 || o_pop_data !== 32'd5) begin errors++; $display("FAIL replace_popped got=%b/%0d want=1/5", o_pop_valid, o_pop_data); end
        checks++; if (o_count !== CW'(1)) begin errors++; $display("FAIL replace_count got=%0d want=1", o_count); end
        drain(2, 60, ok);
        checks++; if (!ok || popped[0] !== 32'd5 || popped[1] !== 32'd2) begin errors++; $display("FAIL replace_next_pop got=%0d pops want=5 then 2", popped.size()); end
    endtask

    task automatic test_hold();
        bit ok;
        do_reset();
        push_val(32'd10);
        cycles(6);
        push_val(32'd1);
        for (int i = 0; i < 10; i++) begin
            checks++; if (o_pop_valid !== 1'b1 || o_pop_data !== 32'd10) begin errors++; $display("FAIL hold_stable cyc=%0d got=%b/%0d want=1/10", i, o_pop_valid, o_pop_data); end
            @(negedge CLK);
        end
        drain(2, 60, ok);
        checks++; if (!ok || popped[0] !== 32'd10 || popped[1] !== 32'd1) begin errors++; $display("FAIL hold_order got=%0d pops want=10 then 1", popped.size()); end
    endtask

    task automatic test_queue_full();
        val_t vals[$];
        val_t exp[$];
        int   acc = 0;
        bit   ok;
        do_reset();
        force_full = 1'b1;
        vals = '{32'd40, 32'd12, 32'd33, 32'd8, 32'd21};
        for (int i = 0; i < 5; i++) begin
            i_push_valid = 1'b1;
            i_push_data  = vals[i];
            if (o_push_ready) acc++;
            @(negedge CLK);
        end
        i_push_valid = 1'b0;
        cycles(6);
        checks++; if (acc !== 4) begin errors++; $display("FAIL full_accepted got=%0d want=4", acc); end
        checks++; if (o_push_ready !== 1'b0) begin errors++; $display("FAIL full_push_ready got=%b want=0", o_push_ready); end
        checks++; if (wrt_seen !== 0) begin errors++; $display("FAIL full_no_wrt got=%0d want=0", wrt_seen); end
        force_full = 1'b0;
        cycles(20);
        checks++; if (wrt_seen !== 4) begin errors++; $display("FAIL full_released_wrt got=%0d want=4", wrt_seen); end
        checks++; if (o_count !== CW'(3)) begin errors++; $display("FAIL full_count got=%0d want=3", o_count); end
        expect_order(vals[0:3], exp);
        drain(4, 80, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_drain_timeout got=%0d want=4 pops", popped.size()); end
        for (int i = 0; i < exp.size() && i < popped.size(); i++) begin
            checks++; if (popped[i] !== exp[i]) begin errors++; $display("FAIL full_order[%0d] got=%0d want=%0d", i, popped[i], exp[i]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_val(32'd8);
        cycles(6);
        force_full = 1'b1;
        push_val(32'd3);
        push_val(32'd4);
        RST = 1'b1;
        @(negedge CLK);
        checks++; if (o_pop_valid !== 1'b0 || o_pop_data !== '0) begin errors++; $display("FAIL midrst_pop got=%b/%0d want=0/0", o_pop_valid, o_pop_data); end
        checks++; if (o_q_wrt !== 1'b0 || o_q_read !== 1'b0 || o_q_node_f !== '0) begin errors++; $display("FAIL midrst_strobes got=%b%b/%0d want=00/0", o_q_wrt, o_q_read, o_q_node_f); end
        checks++; if (o_push_ready !== 1'b1 || o_count !== '0) begin errors++; $display("FAIL midrst_ctrl got=%b/%0d want=1/0", o_push_ready, o_count); end
        RST = 1'b0;
        force_full = 1'b0;
        wrt_seen = 0;
        cycles(8);
        checks++; if (wrt_seen !== 0 || o_pop_valid !== 1'b0) begin errors++; $display("FAIL midrst_discard got=%0d/%b want=0/0", wrt_seen, o_pop_valid); end
    endtask

    task automatic test_sentinel();
        do_reset();
        push_val(all_ones);
        cycles(8);
`ifdef OPEN_LIST_SENTINEL_CHECK_EN
        checks++; if (wrt_seen !== 0) begin errors++; $display("FAIL sentinel_dropped got=%0d want=0", wrt_seen); end
        checks++; if (o_sentinel_err !== 1'b1) begin errors++; $display("FAIL sentinel_err got=%b want=1", o_sentinel_err); end
        push_val(32'd4);
        cycles(8);
        checks++; if (wrt_seen !== 1 || last_wrt_f !== 32'd4) begin errors++; $display("FAIL sentinel_next got=%0d/%0d want=1/4", wrt_seen, last_wrt_f); end
        checks++; if (o_sentinel_err !== 1'b1) begin errors++; $display("FAIL sentinel_sticky got=%b want=1", o_sentinel_err); end
        checks++; if (o_pop_valid !== 1'b1 || o_pop_data !== 32'd4) begin errors++; $display("FAIL sentinel_pop got=%b/%0d want=1/4", o_pop_valid, o_pop_data); end
`else
        checks++; if (wrt_seen !== 1 || last_wrt_f !== all_ones) begin errors++; $display("FAIL sentinel_forward got=%0d/%0h want=1/ffffffff", wrt_seen, last_wrt_f); end
        checks++; if (o_sentinel_err !== 1'b0) begin errors++; $display("FAIL sentinel_tied got=%b want=0", o_sentinel_err); end
        checks++; if (o_pop_valid !== 1'b1 || o_pop_data !== all_ones) begin errors++; $display("FAIL sentinel_pop got=%b/%0h want=1/ffffffff", o_pop_valid, o_pop_data); end
`endif
    endtask

    task automatic test_random_sorted();
        for (int r = 0; r < 4; r++) begin
            val_t src[$];
            val_t exp[$];
            bit   ok;
            int   n = $urandom_range(2, 9);
            do_reset();
            for (int i = 0; i < n; i++) src.push_back(val_t'($urandom_range(0, 5000)));
            foreach (src[i]) push_val(src[i]);
            cycles(4 * n + 10);
            expect_order(src, exp);
            drain(n, 300, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rsort_timeout round=%0d got=%0d want=%0d", r, popped.size(), n); end
            for (int i = 0; i < exp.size() && i < popped.size(); i++) begin
                checks++; if (popped[i] !== exp[i]) begin errors++; $display("FAIL rsort_order r=%0d i=%0d got=%0d want=%0d", r, i, popped[i], exp[i]); end
            end
        end
    endtask

    task automatic test_random_mixed();
        val_t a[$];
        val_t b[$];
        bit   ok;
        int   expc;
        do_reset();
        for (int c = 0; c < 200; c++) begin
            i_push_valid = ($urandom_range(0, 1) == 1);
            i_push_data  = val_t'($urandom_range(0, 10000));
            i_pop_ready  = ($urandom_range(0, 2) != 0);
            expc = qmem.size() + ((o_q_wrt && !o_q_read) ? 1 : 0) - ((o_q_read && !o_q_wrt) ? 1 : 0);
            checks++; if (int'(o_count) !== expc) begin errors++; $display("FAIL mixed_count cyc=%0d got=%0d want=%0d", c, o_count, expc); end
            @(negedge CLK);
        end
        i_push_valid = 1'b0;
        cycles(10);
        drain(pushed.size(), 600, ok);
        checks++; if (!ok || popped.size() != pushed.size()) begin errors++; $display("FAIL mixed_total got=%0d want=%0d", popped.size(), pushed.size()); end
        a = pushed;
        b = popped;
        a.sort();
        b.sort();
        for (int i = 0; i < a.size() && i < b.size(); i++) begin
            checks++; if (b[i] !== a[i]) begin errors++; $display("FAIL mixed_multiset i=%0d got=%0d want=%0d", i, b[i], a[i]); end
        end
        cycles(4);
        checks++; if (o_count !== '0 || o_pop_valid !== 1'b0) begin errors++; $display("FAIL mixed_idle got=%0d/%b want=0/0", o_count, o_pop_valid); end
    endtask

    task automatic test_push_stalls();
        checks++; if (push_stalls !== 0) begin errors++; $display("FAIL push_stalls got=%0d want=0", push_stalls); end
    endtask

    initial begin
        test_reset();
        test_sorted_drain();
        test_replace();
        test_hold();
        test_queue_full();
        test_reset_mid();
        test_sentinel();
        test_random_sorted();
        test_random_mixed();
        test_push_stalls();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
